// File: rtl/instr_encoder_loader.sv
// Program loader: packs symbolic RV32I instructions into 32-bit words and
// writes them to consecutive instruction-memory addresses, one per cycle.
module instr_encoder_loader #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DEPTH  = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_kind,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic              in_funct7b5,
  input  logic [20:0]       in_imm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              err
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  localparam logic [2:0] KIND_LW    = 3'd0;
  localparam logic [2:0] KIND_SW    = 3'd1;
  localparam logic [2:0] KIND_R     = 3'd2;
  localparam logic [2:0] KIND_BEQ   = 3'd3;
  localparam logic [2:0] KIND_I     = 3'd4;
  localparam logic [2:0] KIND_JAL   = 3'd5;
  localparam logic [2:0] KIND_STALL = 3'd7;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              err_q, err_d;

  logic        full_c;
  logic        accept_c;
  logic        fits12_c;
  logic        fits13_c;
  logic        illegal_c;
  logic [31:0] word_c;

  assign full_c   = (count_q == CNT_W'(DEPTH));
  assign accept_c = in_valid && !full_c && !flush;

  // Sign-extension checks: all bits above the immediate's sign bit must match it.
  assign fits12_c = (&in_imm[20:11]) || !(|in_imm[20:11]);
  assign fits13_c = (&in_imm[20:12]) || !(|in_imm[20:12]);

  // Instruction packing and legality for the offered item.
  always_comb begin
    word_c    = 32'h0000_0000;
    illegal_c = 1'b0;
    unique case (in_kind)
      KIND_LW: begin
        word_c    = {in_imm[11:0], in_rs1, 3'b010, in_rd, OP_LOAD};
        illegal_c = !fits12_c;
      end
      KIND_SW: begin
        word_c    = {in_imm[11:5], in_rs2, in_rs1, 3'b010, in_imm[4:0], OP_STORE};
        illegal_c = !fits12_c;
      end
      KIND_R: begin
        word_c = {1'b0, in_funct7b5, 5'b00000, in_rs2, in_rs1, in_funct3, in_rd, OP_R};
      end
      KIND_BEQ: begin
        word_c    = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, 3'b000,
                     in_imm[4:1], in_imm[11], OP_BRANCH};
        illegal_c = !fits13_c || in_imm[0];
      end
      KIND_I: begin
        word_c    = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_IMM};
        illegal_c = !fits12_c;
      end
      KIND_JAL: begin
        word_c    = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, OP_JAL};
        illegal_c = in_imm[0];
      end
      KIND_STALL: begin
        word_c = 32'h0000_0000;
      end
      default: begin
        illegal_c = 1'b1;
      end
    endcase
  end

  // Next-state: flush dominates; legal accepts write, illegal accepts only flag.
  always_comb begin
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    count_d = count_q;
    err_d   = err_q;
    if (flush) begin
      addr_d  = '0;
      count_d = '0;
      err_d   = 1'b0;
    end else if (accept_c) begin
      if (illegal_c) begin
        err_d = 1'b1;
      end else begin
        we_d    = 1'b1;
        addr_d  = ADDR_W'(count_q);
        wdata_d = word_c;
        count_d = count_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'h0000_0000;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  assign in_ready   = !full_c;
  assign full       = full_c;
  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign count      = count_q;
  assign err        = err_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader: a 64-deep instance for encodings and
// error paths, a 4-deep instance sharing the same inputs for fill and flush.
module tb_instr_encoder_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic [2:0]  in_kind;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [2:0]  in_funct3;
  logic        in_funct7b5;
  logic [20:0] in_imm;

  logic        rdy64, we64, full64, err64;
  logic [5:0]  addr64;
  logic [31:0] wdata64;
  logic [6:0]  cnt64;

  logic        rdy4, we4, full4, err4;
  logic [1:0]  addr4;
  logic [31:0] wdata4;
  logic [2:0]  cnt4;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  instr_encoder_loader #(.ADDR_W(6), .DEPTH(64)) dut64 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(rdy64),
    .in_kind(in_kind), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7b5(in_funct7b5), .in_imm(in_imm),
    .imem_we(we64), .imem_addr(addr64), .imem_wdata(wdata64),
    .count(cnt64), .full(full64), .err(err64)
  );

  instr_encoder_loader #(.ADDR_W(2), .DEPTH(4)) dut4 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(rdy4),
    .in_kind(in_kind), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7b5(in_funct7b5), .in_imm(in_imm),
    .imem_we(we4), .imem_addr(addr4), .imem_wdata(wdata4),
    .count(cnt4), .full(full4), .err(err4)
  );

  typedef struct {
    string       name;
    logic [2:0]  kind;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic        f7;
    logic [20:0] imm;
    logic        legal;
    logic [31:0] word;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string name, logic [2:0] kind, logic [4:0] rd, logic [4:0] rs1,
                              logic [4:0] rs2, logic [2:0] f3, logic f7, logic [20:0] imm,
                              logic legal, logic [31:0] word);
    vec_t v;
    v.name = name; v.kind = kind; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
    v.f3 = f3; v.f7 = f7; v.imm = imm; v.legal = legal; v.word = word;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_item(vec_t v);
    in_kind = v.kind; in_rd = v.rd; in_rs1 = v.rs1; in_rs2 = v.rs2;
    in_funct3 = v.f3; in_funct7b5 = v.f7; in_imm = v.imm;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  vec_t v_lw, v_add, v_sub, v_stall, v_bad;
  logic [31:0] exp_cnt;
  logic        exp_err;

  initial begin
    v_lw    = mk("lw",    3'd0, 5'd5, 5'd2, 5'd0, 3'd0, 1'b0, 21'd8, 1'b1, 32'h00812283);
    v_add   = mk("add",   3'd2, 5'd3, 5'd1, 5'd2, 3'd0, 1'b0, 21'd0, 1'b1, 32'h002081B3);
    v_sub   = mk("sub",   3'd2, 5'd3, 5'd1, 5'd2, 3'd0, 1'b1, 21'd0, 1'b1, 32'h402081B3);
    v_stall = mk("stall", 3'd7, 5'd31, 5'd17, 5'd9, 3'd5, 1'b1, 21'h1ABCD, 1'b1, 32'h0);
    v_bad   = mk("kind6", 3'd6, 5'd1, 5'd1, 5'd1, 3'd0, 1'b0, 21'd0, 1'b0, 32'h0);

    vecs.push_back(v_lw);
    vecs.push_back(mk("add_imm_ignored", 3'd2, 5'd3, 5'd1, 5'd2, 3'd0, 1'b0, 21'h155, 1'b1, 32'h002081B3));
    vecs.push_back(v_sub);
    vecs.push_back(mk("beq_m4",   3'd3, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 21'h1FFFFC, 1'b1, 32'hFE208EE3));
    vecs.push_back(mk("jal_8",    3'd5, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 21'd8, 1'b1, 32'h008000EF));
    vecs.push_back(mk("sw_m8",    3'd1, 5'd0, 5'd2, 5'd5, 3'd0, 1'b0, 21'h1FFFF8, 1'b1, 32'hFE512C23));
    vecs.push_back(mk("addi_m1",  3'd4, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 21'h1FFFFF, 1'b1, 32'hFFF00093));
    vecs.push_back(mk("andi_255", 3'd4, 5'd4, 5'd4, 5'd0, 3'd7, 1'b0, 21'd255, 1'b1, 32'h0FF27213));
    vecs.push_back(v_stall);
    vecs.push_back(v_bad);
    vecs.push_back(mk("beq_odd",  3'd3, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 21'd3, 1'b0, 32'h0));
    vecs.push_back(mk("lw_2048",  3'd0, 5'd5, 5'd2, 5'd0, 3'd0, 1'b0, 21'd2048, 1'b0, 32'h0));
    vecs.push_back(v_lw);
    vecs.push_back(mk("lw_2047",  3'd0, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 21'd2047, 1'b1, 32'h7FF02083));
    vecs.push_back(mk("lw_m2048", 3'd0, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 21'h1FF800, 1'b1, 32'h80002083));
    vecs.push_back(mk("lw_m2049", 3'd0, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 21'h1FF7FF, 1'b0, 32'h0));
    vecs.push_back(mk("beq_4094", 3'd3, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 21'd4094, 1'b1, 32'h7E000FE3));
    vecs.push_back(mk("beq_4096", 3'd3, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 21'd4096, 1'b0, 32'h0));
    vecs.push_back(mk("jal_odd",  3'd5, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 21'd3, 1'b0, 32'h0));
    vecs.push_back(mk("jal_m2",   3'd5, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 21'h1FFFFE, 1'b1, 32'hFFFFF06F));

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0;
    set_item(v_lw);
    #3;
    chk("rst_we",    32'(we64), 32'd0);
    chk("rst_addr",  32'(addr64), 32'd0);
    chk("rst_wdata", wdata64, 32'd0);
    chk("rst_count", 32'(cnt64), 32'd0);
    chk("rst_err",   32'(err64), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_full",  32'(full64), 32'd0);
    chk("rst_ready", 32'(rdy64), 32'd1);

    // Table: one item per accept followed by an idle cycle.
    exp_cnt = 0;
    exp_err = 1'b0;
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      set_item(vecs[i]);
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      chk({vecs[i].name, "_we"}, 32'(we64), 32'(vecs[i].legal));
      if (vecs[i].legal) begin
        chk({vecs[i].name, "_addr"},  32'(addr64), exp_cnt);
        chk({vecs[i].name, "_wdata"}, wdata64, vecs[i].word);
        exp_cnt = exp_cnt + 1;
      end else begin
        exp_err = 1'b1;
      end
      chk({vecs[i].name, "_count"}, 32'(cnt64), exp_cnt);
      chk({vecs[i].name, "_err"},   32'(err64), 32'(exp_err));
      step();
      chk({vecs[i].name, "_idle_we"}, 32'(we64), 32'd0);
    end

    // Back-to-back R-type writes on consecutive cycles.
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_err", 32'(err64), 32'd0);
    set_item(v_add); in_valid = 1'b1;
    step();
    set_item(v_sub);
    chk("b2b0_we",    32'(we64), 32'd1);
    chk("b2b0_addr",  32'(addr64), 32'd0);
    chk("b2b0_wdata", wdata64, 32'h002081B3);
    step();
    in_valid = 1'b0;
    chk("b2b1_we",    32'(we64), 32'd1);
    chk("b2b1_addr",  32'(addr64), 32'd1);
    chk("b2b1_wdata", wdata64, 32'h402081B3);
    chk("b2b_count",  32'(cnt64), 32'd2);

    // Fill the 4-deep loader with stall words.
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("fill_start_count", 32'(cnt4), 32'd0);
    set_item(v_stall); in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("fill%0d_we", i),    32'(we4), 32'd1);
      chk($sformatf("fill%0d_addr", i),  32'(addr4), 32'(i));
      chk($sformatf("fill%0d_wdata", i), wdata4, 32'd0);
      chk($sformatf("fill%0d_count", i), 32'(cnt4), 32'(i + 1));
    end
    chk("fill_full",  32'(full4), 32'd1);
    chk("fill_ready", 32'(rdy4), 32'd0);
    set_item(v_lw);
    for (int i = 0; i < 2; i++) begin
      step();
      chk($sformatf("held%0d_we", i),    32'(we4), 32'd0);
      chk($sformatf("held%0d_count", i), 32'(cnt4), 32'd4);
      chk($sformatf("held%0d_addr", i),  32'(addr4), 32'd3);
    end

    // Flush while full with an item offered: item is dropped.
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("fl_full_count", 32'(cnt4), 32'd0);
    chk("fl_full_err",   32'(err4), 32'd0);
    chk("fl_full_ready", 32'(rdy4), 32'd1);
    chk("fl_full_we",    32'(we4), 32'd0);
    chk("fl_drop_we64",  32'(we64), 32'd0);
    chk("fl_drop_cnt64", 32'(cnt64), 32'd0);

    // Sticky error cleared only by flush.
    set_item(v_bad); in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("err_set",    32'(err4), 32'd1);
    chk("err_cnt",    32'(cnt4), 32'd0);
    step();
    chk("err_sticky", 32'(err4), 32'd1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("err_clear",  32'(err4), 32'd0);

    // A registered write completes in the flush cycle; nothing follows it.
    set_item(v_lw); in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    flush = 1'b1;
    chk("flwr_we",    32'(we4), 32'd1);
    chk("flwr_wdata", wdata4, 32'h00812283);
    step();
    flush = 1'b0;
    chk("flwr_after_we",    32'(we4), 32'd0);
    chk("flwr_after_count", 32'(cnt4), 32'd0);
    chk("flwr_after_addr",  32'(addr4), 32'd0);

    // Async reset mid-stream discards the pending write immediately.
    set_item(v_lw); in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("rstm_pre_we", 32'(we4), 32'd1);
    reset = 1'b1;
    #1;
    chk("rstm_we",    32'(we4), 32'd0);
    chk("rstm_count", 32'(cnt4), 32'd0);
    chk("rstm_wdata", wdata4, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    step();
    chk("rstm_ready", 32'(rdy4), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
- Sequential counterpart to the control decoder: the encoder side of the RV32I opcode/control interface.
- Accepts symbolic instructions over a valid/ready handshake: kind, register fields, funct bits and a signed immediate.
- Packs each instruction into a 32-bit RV32I word in the layout the decoder expects, then writes it to consecutive word addresses of instruction memory.
- Used as the program loader/bootstrap for the single-cycle and pipelined cores and their benches.

Parameters:
ADDR_W, 6, width of the instruction-memory word address.
DEPTH, 64, number of loadable words; must satisfy 1 <= DEPTH <= 2^ADDR_W.

Ports:
clk  input  1  clock, rising edge.
reset  input  1  asynchronous, active-high reset.
flush  input  1  synchronous clear of the load session.
in_valid  input  1  instruction fields valid.
in_ready  output  1  block can accept; combinational, equal to !full.
in_kind  input  3  0 lw, 1 sw, 2 R-type, 3 beq, 4 I-type ALU, 5 jal, 6 reserved (illegal), 7 stall word.
in_rd  input  5  destination register.
in_rs1  input  5  source register 1.
in_rs2  input  5  source register 2.
in_funct3  input  3  used by R-type and I-type ALU only.
in_funct7b5  input  1  bit 30 for R-type; ignored for other kinds.
in_imm  input  21  signed immediate, two's complement; byte offset for beq/jal.
imem_we  output  1  one-cycle write strobe.
imem_addr  output  ADDR_W  word address.
imem_wdata  output  32  encoded instruction.
count  output  ADDR_W+1  words written so far.
full  output  1  count == DEPTH.
err  output  1  sticky error flag.

Behaviour:
- Reset (async): imem_we=0, imem_addr=0, imem_wdata=0, count=0, err=0. full=0 and in_ready=1 after release.
- Accept condition: in_valid && in_ready at a rising edge. in_ready never depends on in_valid.
- Latency: exactly one registered stage.
  - For a legal item accepted at edge N, imem_we=1 for the cycle following edge N.
  - imem_addr = count value before the accept; imem_wdata = encoded word.
  - count increments at edge N, so full/in_ready reflect the item immediately and no overfill is possible.
- Back-to-back accepts are allowed: one word per cycle.
- Encodings (imm bits are in_imm bits):
  - lw: imm[11:0], rs1, 010, rd, 0000011.
  - sw: imm[11:5], rs2, rs1, 010, imm[4:0], 0100011.
  - R-type: 0, funct7b5, 00000, rs2, rs1, funct3, rd, 0110011.
  - beq: imm[12], imm[10:5], rs2, rs1, 000, imm[4:1], imm[11], 1100011.
  - I-type ALU: imm[11:0], rs1, funct3, rd, 0010011.
  - jal: imm[20], imm[10:1], imm[11], imm[19:12], rd, 1101111.
  - stall: 32'h00000000, matching the decoder's stall opcode.
- Illegal items are accepted (handshake completes) but cause no write and no count change; err is set the next cycle and stays set until flush or reset. An item is illegal when:
  - kind is 6;
  - lw, sw or I-type ALU immediate does not fit signed 12 bits (imm[20:11] not all equal);
  - beq immediate does not fit signed 13 bits, or imm[0] = 1;
  - jal has imm[0] = 1.
- Unused fields are ignored: not checked, no effect on the encoded word.
- Full: when count == DEPTH, full=1 and in_ready=0; in_valid is ignored. No wrap-around.
- flush at an edge: count=0, err=0, imem_addr=0.
  - Any item offered in that cycle is not accepted.
  - A write already registered from the previous edge still completes in the current cycle.
  - imem_we is 0 in the cycle after the flush edge.
- Reset mid-stream: the pending write is discarded and imem_we drops immediately.

Test Plan:
- Single lw, DEPTH=64: kind0 rd=5 rs1=2 imm=8 -> next cycle imem_we=1, addr=0, wdata=32'h00812283; count=1.
- R-type back-to-back: add x3,x1,x2 then sub (funct7b5=1) -> consecutive cycles write addr0 32'h002081B3 and addr1 32'h402081B3.
- Branch/jump: beq x1,x2,-4 -> 32'hFE208EE3; jal rd=1 imm=8 -> 32'h008000EF.
- Error paths: kind6; beq imm=3; lw imm=2048 -> each accepted, no imem_we, err=1, count unchanged; a following lw is written at the unchanged address.
- Stall and fill, DEPTH=4: four stall items -> four writes of 0 at addr 0..3; after the 4th accept full=1 and in_ready=0; a held in_valid causes no write.
- Flush, DEPTH=4: flush while full -> next cycle count=0, err=0, in_ready=1; a flush coinciding with in_valid drops that item.
